serial_bit_feeder: RTL and testbench

Upstream feeder for the Moore sequence detector. It accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on a serial line that connects directly to the detector's `din`. Back-to-back words stream with no idle gap, so patterns that span a word boundary are still seen. A per-bit qualifier marks the cycles that carry real data.

---
 rtl/serial_bit_feeder.sv | 90 +++++++++
 tb/tb_serial_bit_feeder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: streams valid/ready parallel words out one bit per clock; even parity bit optional via SERIAL_FEEDER_PARITY_EN
module serial_bit_feeder #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             dout,
   output logic             dout_valid,
   output logic             busy
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`ifdef SERIAL_FEEDER_PARITY_EN
   localparam state_t END_ST = PARITY;
`else
   localparam state_t END_ST = IDLE;
`endif
   state_t state, state_n;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic [CW-1:0] cnt;
   logic last, accept, step;

   function automatic logic head(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   assign shreg_nxt = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
   assign last      = cnt == CW'(WIDTH-1);
   assign step      = state == SHIFT && !last;
   assign busy      = state != IDLE;
   assign accept    = in_valid && in_ready;
`ifdef SERIAL_FEEDER_PARITY_EN
   assign in_ready  = state == IDLE || state == PARITY;
`else
   assign in_ready  = state == IDLE || (state == SHIFT && last);
`endif

   // state register; reset drops any word in flight
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) state <= IDLE;
      else state <= state_n;

   // next state: a new word always wins, otherwise finish the word and fall back to idle
   always_comb begin
      state_n = state;
      if (accept) state_n = SHIFT;
      else if (state == SHIFT && last) state_n = END_ST;
      else if (state == PARITY) state_n = IDLE;
   end

`ifdef SERIAL_FEEDER_PARITY_EN
   logic par;
   // running XOR of every bit already placed on dout for the current word
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) par <= 1'b0;
      else if (accept) par <= head(in_data);
      else if (step) par <= par ^ head(shreg_nxt);
`endif

   // datapath: first bit leaves on the accept edge, one more per edge, zeros when nothing to send
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         shreg      <= '0;
         cnt        <= '0;
         dout       <= 1'b0;
         dout_valid <= 1'b0;
      end else if (accept) begin
         shreg      <= in_data;
         cnt        <= '0;
         dout       <= head(in_data);
         dout_valid <= 1'b1;
      end else if (step) begin
         shreg      <= shreg_nxt;
         cnt        <= cnt + CW'(1);
         dout       <= head(shreg_nxt);
         dout_valid <= 1'b1;
`ifdef SERIAL_FEEDER_PARITY_EN
      end else if (state == SHIFT) begin
         dout       <= par;
         dout_valid <= 1'b1;
`endif
      end else begin
         dout       <= 1'b0;
         dout_valid <= 1'b0;
      end
endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb_serial_bit_feeder: queue-based reference model plus directed literal checks for both bit orders
module tb_serial_bit_feeder;
   localparam int W = 8;
`ifdef SERIAL_FEEDER_PARITY_EN
   localparam int NB = W + 1;
`else
   localparam int NB = W;
`endif
   logic clk = 1'b0, rstn = 1'b0, in_valid = 1'b0;
   logic [W-1:0] in_data = '0;
   logic rdy_a, dout_a, dv_a, busy_a, rdy_b, dout_b, dv_b, busy_b;
   int n_cmp = 0, n_bad = 0;
   bit qa[$], qb[$];
   logic m_d_a = 1'b0, m_d_b = 1'b0, m_v = 1'b0, m_acc = 1'b0;
   int run = 0, run_max = 0;

   serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy_a), .dout(dout_a), .dout_valid(dv_a), .busy(busy_a));
   serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy_b), .dout(dout_b), .dout_valid(dv_b), .busy(busy_b));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference: each accepted word becomes a queue of line bits; the line shows one per edge
   initial forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
         qa.delete();
         qb.delete();
         m_d_a = 1'b0;
         m_d_b = 1'b0;
         m_v   = 1'b0;
         m_acc = 1'b0;
      end else begin
         m_acc = in_valid && qa.size() == 0;
         if (m_acc) begin
            for (int i = 0; i < W; i++) begin
               qa.push_back(in_data[W-1-i]);
               qb.push_back(in_data[i]);
            end
`ifdef SERIAL_FEEDER_PARITY_EN
            qa.push_back(^in_data);
            qb.push_back(^in_data);
`endif
         end
         m_v = qa.size() != 0;
         m_d_a = 1'b0;
         m_d_b = 1'b0;
         if (m_v) begin
            m_d_a = qa.pop_front();
            m_d_b = qb.pop_front();
         end
      end
   end

   // every-cycle comparison against the reference, away from the active edge
   initial forever begin
      @(negedge clk);
      check("ready_msb", rdy_a, qa.size() == 0);
      check("dout_msb", dout_a, m_d_a);
      check("valid_msb", dv_a, m_v);
      check("busy_msb", busy_a, m_v);
      check("ready_lsb", rdy_b, qb.size() == 0);
      check("dout_lsb", dout_b, m_d_b);
      check("valid_lsb", dv_b, m_v);
      check("busy_lsb", busy_b, m_v);
      run = dv_a ? run + 1 : 0;
      if (run > run_max) run_max = run;
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [W-1:0] w);
      in_data  = w;
      in_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (m_acc) return;
      end
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: word %0h never accepted, required accept within 40 cycles", w);
   endtask

   task automatic grab(output logic [7:0] a, output logic [7:0] b);
      a = '0;
      b = '0;
      for (int i = 0; i < W; i++) begin
         a = {a[6:0], dout_a};
         b = {b[6:0], dout_b};
         tick(1);
      end
   endtask

   initial begin
      logic [7:0] sa, sb;
      #1;
      check("reset_dout", dout_a, 0);
      check("reset_valid", dv_a, 0);
      check("reset_busy", busy_a, 0);
      check("reset_ready", rdy_a, 1);
      #20 rstn = 1'b1;
      tick(1);
      send(8'hB0);
      in_valid = 1'b0;
      grab(sa, sb);
      check("b0_seq_msb", sa, 8'hB0);
      check("b0_seq_lsb", sb, 8'h0D);
`ifdef SERIAL_FEEDER_PARITY_EN
      check("b0_parity", dout_a, 1);
      tick(1);
`endif
      check("b0_end_valid", dv_a, 0);
      run_max = 0;
      send(8'h0B);
      send(8'hB0);
      in_valid = 1'b0;
      tick(NB + 3);
      check("b2b_run", run_max, 2 * NB);
      check("gap_valid", dv_b, 0);
      check("gap_dout", dout_b, 0);
      send(8'h0D);
      in_valid = 1'b0;
      grab(sa, sb);
      check("0d_seq_msb", sa, 8'h0D);
      check("0d_seq_lsb", sb, 8'hB0);
`ifdef SERIAL_FEEDER_PARITY_EN
      tick(2);
      send(8'hF0);
      in_valid = 1'b0;
      grab(sa, sb);
      check("f0_seq_msb", sa, 8'hF0);
      check("f0_parity", dout_a, 0);
      check("f0_parity_valid", dv_a, 1);
`endif
      tick(3);
      send(8'hFF);
      in_valid = 1'b0;
      tick(3);
      check("mid_bit3_valid", dv_a, 1);
      #2 rstn = 1'b0;
      #1;
      check("rst_dout", dout_a, 0);
      check("rst_valid", dv_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_ready", rdy_a, 1);
      rstn = 1'b1;
      tick(1);
      for (int i = 0; i < 3; i++) begin
         check("no_residual", dv_a, 0);
         tick(1);
      end
      send(8'hB0);
      in_valid = 1'b0;
      grab(sa, sb);
      check("after_rst_msb", sa, 8'hB0);
      check("after_rst_lsb", sb, 8'h0D);
      for (int c = 0; c < 2000; c++) begin
         if (!in_valid || m_acc) begin
            in_valid = $urandom_range(0, 3) != 0;
            in_data  = W'($urandom);
         end
         if ($urandom_range(0, 149) == 0) begin
            #1 rstn = 1'b0;
            #2 rstn = 1'b1;
         end
         tick(1);
      end
      in_valid = 1'b0;
      tick(NB + 2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
